// File: rtl/fpu_div_pkg.sv
// rtl/fpu_div_pkg.sv - shared types and helpers for the F32 divide issue stage
package fpu_div_pkg;

  localparam int DIV_TAG_W = 4;
  localparam logic [31:0] F32_QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {ZERO, SUBN, NORM, INF, QNAN, SNAN} f32_class_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} skid_state_t;

  typedef struct packed {
    logic [31:0]          a;
    logic [31:0]          b;
    logic [DIV_TAG_W-1:0] tag;
    logic                 special;
    logic [31:0]          special_val;
    logic [1:0]           flags;      // {NV, DZ}
  } div_entry_t;

  // Subnormals become a zero of the same sign; every other encoding is untouched.
  function automatic logic [31:0] f32_ftz(input logic [31:0] x, input logic ftz);
    if (ftz && (x[30:23] == 8'h00)) return {x[31], 31'h0};
    return x;
  endfunction

endpackage

// File: rtl/fpu_f32_classify.sv
// rtl/fpu_f32_classify.sv - binary32 operand class decode
module fpu_f32_classify
  import fpu_div_pkg::*;
#(
  parameter bit FTZ = 1'b1
) (
  input  logic [31:0] x_i,
  output f32_class_t  cls_o
);

  logic [7:0]  exp_w;
  logic [22:0] man_w;

  assign exp_w = x_i[30:23];
  assign man_w = x_i[22:0];

  always_comb begin
    cls_o = NORM;
    if (exp_w == 8'hFF) begin
      if (man_w == 23'h0)  cls_o = INF;
      else if (man_w[22])  cls_o = QNAN;
      else                 cls_o = SNAN;
    end else if (exp_w == 8'h00) begin
      if (man_w == 23'h0)  cls_o = ZERO;
      else if (FTZ)        cls_o = ZERO;
      else                 cls_o = SUBN;
    end
  end

endmodule

// File: rtl/fpu_f32_div_issue.sv
// rtl/fpu_f32_div_issue.sv - divider issue stage: 2-entry skid buffer with
// special-case classification and FTZ operand cleanup
module fpu_f32_div_issue
  import fpu_div_pkg::*;
#(
  parameter int TAG_W = DIV_TAG_W,
  parameter bit FTZ   = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      IN_A,
  input  logic [31:0]      IN_B,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      OUT_A,
  output logic [31:0]      OUT_B,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             OUT_SPECIAL,
  output logic [31:0]      OUT_SPECIAL_VAL,
  output logic [1:0]       OUT_FLAGS
);

  f32_class_t  cls_a, cls_b;
  div_entry_t  new_e;
  div_entry_t  main_q, main_d, skid_q, skid_d;
  skid_state_t state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        push, pop, sgn;
  logic        a_nan, b_nan, a_zero, b_zero, a_inf, b_inf, a_fin_nz;

  fpu_f32_classify #(.FTZ(FTZ)) u_cls_a (.x_i(IN_A), .cls_o(cls_a));
  fpu_f32_classify #(.FTZ(FTZ)) u_cls_b (.x_i(IN_B), .cls_o(cls_b));

  assign sgn      = IN_A[31] ^ IN_B[31];
  assign a_nan    = (cls_a == QNAN) || (cls_a == SNAN);
  assign b_nan    = (cls_b == QNAN) || (cls_b == SNAN);
  assign a_zero   = (cls_a == ZERO);
  assign b_zero   = (cls_b == ZERO);
  assign a_inf    = (cls_a == INF);
  assign b_inf    = (cls_b == INF);
  assign a_fin_nz = (cls_a == NORM) || (cls_a == SUBN);

  // Priority chain: earlier branches shadow later ones, so each test may
  // assume the operands already excluded above.
  always_comb begin
    new_e     = '0;
    new_e.a   = f32_ftz(IN_A, FTZ);
    new_e.b   = f32_ftz(IN_B, FTZ);
    new_e.tag = IN_TAG;
    if (a_nan || b_nan) begin
      new_e.special     = 1'b1;
      new_e.special_val = F32_QNAN;
      new_e.flags[1]    = (cls_a == SNAN) || (cls_b == SNAN);
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      new_e.special     = 1'b1;
      new_e.special_val = F32_QNAN;
      new_e.flags[1]    = 1'b1;
    end else if (a_fin_nz && b_zero) begin
      new_e.special     = 1'b1;
      new_e.special_val = {sgn, 8'hFF, 23'h0};
      new_e.flags[0]    = 1'b1;
    end else if (a_inf) begin
      new_e.special     = 1'b1;
      new_e.special_val = {sgn, 8'hFF, 23'h0};
    end else if (a_zero || b_inf) begin
      new_e.special     = 1'b1;
      new_e.special_val = {sgn, 31'h0};
    end
  end

  assign push = IN_VALID && in_ready_q;
  assign pop  = (state_q != ST_EMPTY) && OUT_READY;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: if (push) begin
        main_d  = new_e;
        state_d = ST_ONE;
      end
      ST_ONE: begin
        if (push && pop) begin
          main_d = new_e;
        end else if (push) begin
          skid_d  = new_e;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: if (pop) begin
        main_d  = skid_q;
        state_d = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign IN_READY        = in_ready_q;
  assign OUT_VALID       = (state_q != ST_EMPTY);
  assign OUT_A           = main_q.a;
  assign OUT_B           = main_q.b;
  assign OUT_TAG         = main_q.tag;
  assign OUT_SPECIAL     = main_q.special;
  assign OUT_SPECIAL_VAL = main_q.special_val;
  assign OUT_FLAGS       = main_q.flags;

endmodule

// File: tb/tb_fpu_f32_div_issue.sv
// tb/tb_fpu_f32_div_issue.sv - directed vector bench for the divide issue stage
module tb_fpu_f32_div_issue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY, OUT_SPECIAL;
  logic [31:0] IN_A, IN_B, OUT_A, OUT_B, OUT_SPECIAL_VAL;
  logic [3:0]  IN_TAG, OUT_TAG;
  logic [1:0]  OUT_FLAGS;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sp;
    logic [31:0] val;
    logic [1:0]  fl;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vecs[13];

  fpu_f32_div_issue dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_A(IN_A), .IN_B(IN_B), .IN_TAG(IN_TAG),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_A(OUT_A), .OUT_B(OUT_B), .OUT_TAG(OUT_TAG),
    .OUT_SPECIAL(OUT_SPECIAL), .OUT_SPECIAL_VAL(OUT_SPECIAL_VAL),
    .OUT_FLAGS(OUT_FLAGS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h00000000, 2'b00, 32'h3F800000, 32'h40000000};
    vecs[1]  = '{32'h3F800000, 32'h00000000, 1'b1, 32'h7F800000, 2'b01, 32'h3F800000, 32'h00000000};
    vecs[2]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h7FC00000, 2'b10, 32'h00000000, 32'h00000000};
    vecs[3]  = '{32'hBF800000, 32'h7F800000, 1'b1, 32'h80000000, 2'b00, 32'hBF800000, 32'h7F800000};
    vecs[4]  = '{32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00000, 2'b10, 32'h7F800001, 32'h3F800000};
    vecs[5]  = '{32'h7FC00000, 32'h3F800000, 1'b1, 32'h7FC00000, 2'b00, 32'h7FC00000, 32'h3F800000};
    vecs[6]  = '{32'h00000001, 32'h3F800000, 1'b1, 32'h00000000, 2'b00, 32'h00000000, 32'h3F800000};
    vecs[7]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2'b10, 32'h7F800000, 32'h7F800000};
    vecs[8]  = '{32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 2'b00, 32'hFF800000, 32'h3F800000};
    vecs[9]  = '{32'h80000000, 32'hC0000000, 1'b1, 32'h00000000, 2'b00, 32'h80000000, 32'hC0000000};
    vecs[10] = '{32'h3F800000, 32'h80000001, 1'b1, 32'hFF800000, 2'b01, 32'h3F800000, 32'h80000000};
    vecs[11] = '{32'h7F800000, 32'h00000000, 1'b1, 32'h7F800000, 2'b00, 32'h7F800000, 32'h00000000};
    vecs[12] = '{32'h3F800000, 32'hFFC00000, 1'b1, 32'h7FC00000, 2'b00, 32'h3F800000, 32'hFFC00000};

    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    IN_A = '0; IN_B = '0; IN_TAG = '0;
    step(); step();
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_a", OUT_A, 0);
    @(negedge CLK); RST = 1'b0;

    // Special-case table, one pair in flight at a time with the consumer ready.
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b1; IN_A = vecs[i].a; IN_B = vecs[i].b; IN_TAG = 4'(i);
      step();
      IN_VALID = 1'b0;
      chk($sformatf("v%0d_valid", i), OUT_VALID, 1);
      chk($sformatf("v%0d_tag", i), OUT_TAG, 32'(i));
      chk($sformatf("v%0d_a", i), OUT_A, vecs[i].ea);
      chk($sformatf("v%0d_b", i), OUT_B, vecs[i].eb);
      chk($sformatf("v%0d_special", i), OUT_SPECIAL, vecs[i].sp);
      chk($sformatf("v%0d_val", i), OUT_SPECIAL_VAL, vecs[i].val);
      chk($sformatf("v%0d_flags", i), OUT_FLAGS, vecs[i].fl);
    end
    step();
    chk("drain_empty", OUT_VALID, 0);

    // Back-to-back pushes drain one per cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b1; IN_A = 32'h3F800000; IN_B = 32'h40000000; IN_TAG = 4'(i + 3);
      step();
      chk($sformatf("tp%0d_tag", i), OUT_TAG, 32'(i + 3));
      chk($sformatf("tp%0d_ready", i), IN_READY, 1);
      chk($sformatf("tp%0d_special", i), OUT_SPECIAL, 0);
    end
    @(negedge CLK); IN_VALID = 1'b0;
    step();
    chk("tp_empty", OUT_VALID, 0);

    // Backpressure: third pair must wait until the skid entry frees up.
    @(negedge CLK); OUT_READY = 1'b0; IN_VALID = 1'b1; IN_TAG = 4'd0;
    step();
    chk("bp0_tag", OUT_TAG, 0);
    chk("bp0_ready", IN_READY, 1);
    @(negedge CLK); IN_TAG = 4'd1;
    step();
    chk("bp1_ready", IN_READY, 0);
    chk("bp1_tag", OUT_TAG, 0);
    @(negedge CLK); IN_TAG = 4'd2;
    step();
    chk("bp2_ready", IN_READY, 0);
    chk("bp2_hold_tag", OUT_TAG, 0);
    chk("bp2_hold_valid", OUT_VALID, 1);
    @(negedge CLK); OUT_READY = 1'b1;
    step();
    chk("bp3_tag", OUT_TAG, 1);
    chk("bp3_ready", IN_READY, 1);
    step();
    chk("bp4_tag", OUT_TAG, 2);
    @(negedge CLK); IN_VALID = 1'b0;
    step();
    chk("bp_empty", OUT_VALID, 0);

    // Reset while FULL drops both entries.
    @(negedge CLK); OUT_READY = 1'b0; IN_VALID = 1'b1; IN_A = 32'h3F800000; IN_TAG = 4'd5;
    step(); step();
    chk("full_ready", IN_READY, 0);
    @(negedge CLK); IN_VALID = 1'b0; RST = 1'b1;
    step();
    chk("rstfull_valid", OUT_VALID, 0);
    chk("rstfull_ready", IN_READY, 1);
    chk("rstfull_a", OUT_A, 0);
    @(negedge CLK); RST = 1'b0; OUT_READY = 1'b1;
    step();
    chk("post_rst_valid", OUT_VALID, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
